// File: rtl/ccc_pkg.sv
// Shared types and helpers for the 4x4 colour-cell-compression encoder.
package ccc_pkg;

    localparam int BITS_PER_PIXEL = 24;
    localparam int BITS_PER_BLOCK = 64;
    localparam int BMP_LSB        = 0;
    localparam int C0_LSB         = 16;
    localparam int C1_LSB         = 40;

    typedef enum logic [2:0] {
        ACCUM    = 3'd0,
        CLASSIFY = 3'd1,
        DIV0     = 3'd2,
        DIV1     = 3'd3,
        OUT      = 3'd4
    } ccc_enc_state_t;

    // Luminance proxy R + 2G + B, at most 1020.
    function automatic logic [9:0] luma(input logic [BITS_PER_PIXEL-1:0] pixel);
        luma = {2'b00, pixel[23:16]} + {1'b0, pixel[15:8], 1'b0} + {2'b00, pixel[7:0]};
    endfunction

endpackage

// File: rtl/ccc_div3.sv
// Three-lane 12-by-5-bit restoring divider sharing one divisor.
// The twelfth quotient bit is produced combinationally, so done marks a valid quotient.
module ccc_div3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [35:0] dividend,
    input  logic [4:0]  divisor,
    output logic        done,
    output logic [23:0] quotient
);

    logic [4:0]  rem_r     [3];
    logic [11:0] sh_r      [3];
    logic [4:0]  dvs_r;
    logic [3:0]  step_r;
    logic        busy_r;

    logic [4:0]  dvs_s;
    logic [4:0]  rem_src_s [3];
    logic [11:0] sh_src_s  [3];
    logic [5:0]  trial_s   [3];
    logic [4:0]  rem_nxt_s [3];
    logic [11:0] sh_nxt_s  [3];

    // One restoring step per lane; a start cycle steps on the fresh operands.
    always_comb begin
        if (start) begin
            dvs_s = divisor;
        end else begin
            dvs_s = dvs_r;
        end
        for (int l = 0; l < 3; l++) begin
            if (start) begin
                rem_src_s[l] = 5'd0;
                sh_src_s[l]  = dividend[l*12 +: 12];
            end else begin
                rem_src_s[l] = rem_r[l];
                sh_src_s[l]  = sh_r[l];
            end
            trial_s[l] = {rem_src_s[l], sh_src_s[l][11]};
            if (trial_s[l] >= {1'b0, dvs_s}) begin
                rem_nxt_s[l] = 5'(trial_s[l] - {1'b0, dvs_s});
                sh_nxt_s[l]  = {sh_src_s[l][10:0], 1'b1};
            end else begin
                rem_nxt_s[l] = trial_s[l][4:0];
                sh_nxt_s[l]  = {sh_src_s[l][10:0], 1'b0};
            end
        end
    end

    assign done     = busy_r && (step_r == 4'd11);
    assign quotient = {sh_nxt_s[2][7:0], sh_nxt_s[1][7:0], sh_nxt_s[0][7:0]};

    // Iteration state: start performs step 1, then one step per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            step_r <= 4'd0;
            dvs_r  <= 5'd0;
            for (int l = 0; l < 3; l++) begin
                rem_r[l] <= 5'd0;
                sh_r[l]  <= 12'd0;
            end
        end else if (start) begin
            busy_r <= 1'b1;
            step_r <= 4'd1;
            dvs_r  <= divisor;
            for (int l = 0; l < 3; l++) begin
                rem_r[l] <= rem_nxt_s[l];
                sh_r[l]  <= sh_nxt_s[l];
            end
        end else if (busy_r) begin
            for (int l = 0; l < 3; l++) begin
                rem_r[l] <= rem_nxt_s[l];
                sh_r[l]  <= sh_nxt_s[l];
            end
            if (step_r == 4'd11) begin
                busy_r <= 1'b0;
                step_r <= 4'd0;
            end else begin
                step_r <= step_r + 4'd1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/ccc_encoder_4x4.sv
// Streaming CCC encoder: 16 RGB888 pixels in, one 64-bit {color1, color0, bitmap} word out.
// Define CCC_ENC_ROUND_EN to round class averages to nearest instead of truncating.
module ccc_encoder_4x4
    import ccc_pkg::*;
#(
    parameter logic signed [14:0] THRESH_BIAS = 15'sd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITS_PER_PIXEL-1:0] in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITS_PER_BLOCK-1:0] out_block
);

    ccc_enc_state_t state_r, state_nxt_s;

    logic [3:0]                cnt_r;
    logic [BITS_PER_PIXEL-1:0] pix_buf_r [16];
    logic [13:0]               ysum_r;
    logic [35:0]               sum0_r, sum1_r;
    logic [4:0]                cnt0_r, cnt1_r;
    logic [15:0]               bmp_r;
    logic [23:0]               avg0_r;
    logic                      in_ready_r, out_valid_r;
    logic [BITS_PER_BLOCK-1:0] out_block_r;

    logic                      accept_s;
    logic [BITS_PER_PIXEL-1:0] cur_pix_s;
    logic signed [15:0]        lhs_s, rhs_s;
    logic                      cls_bit_s;
    logic [35:0]               div_sum_s, div_dvd_s;
    logic [4:0]                div_dvs_s;
    logic [11:0]               rnd_s;
    logic                      div_start_s, div_done_s;
    logic [23:0]               div_quo_s;
    logic [23:0]               c0_s, c1_s;

    assign accept_s = in_valid && in_ready_r && (state_r == ACCUM);

    // Threshold compare of the pixel under classification against the block mean.
    always_comb begin
        cur_pix_s = pix_buf_r[cnt_r];
        lhs_s     = {2'b00, luma(cur_pix_s), 4'b0000} + {THRESH_BIAS[14], THRESH_BIAS};
        rhs_s     = {2'b00, ysum_r};
        cls_bit_s = (lhs_s > rhs_s);
    end

    // Divider operands: class0 during DIV0, class1 during DIV1.
    always_comb begin
        if (state_r == DIV1) begin
            div_sum_s = sum1_r;
            div_dvs_s = cnt1_r;
        end else begin
            div_sum_s = sum0_r;
            div_dvs_s = cnt0_r;
        end
`ifdef CCC_ENC_ROUND_EN
        rnd_s = {8'd0, div_dvs_s[4:1]};
`else
        rnd_s = 12'd0;
`endif
        for (int l = 0; l < 3; l++) begin
            div_dvd_s[l*12 +: 12] = div_sum_s[l*12 +: 12] + rnd_s;
        end
        div_start_s = ((state_r == DIV0) || (state_r == DIV1)) && (cnt_r == 4'd0);
    end

    ccc_div3 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (div_dvd_s),
        .divisor  (div_dvs_s),
        .done     (div_done_s),
        .quotient (div_quo_s)
    );

    // An empty class borrows the other class's colour.
    always_comb begin
        if (cnt1_r == 5'd0) begin
            c1_s = avg0_r;
        end else begin
            c1_s = div_quo_s;
        end
        if (cnt0_r == 5'd0) begin
            c0_s = div_quo_s;
        end else begin
            c0_s = avg0_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && (cnt_r == 4'd15)) begin
                    state_nxt_s = CLASSIFY;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            CLASSIFY: begin
                if (cnt_r == 4'd15) begin
                    state_nxt_s = DIV0;
                end else begin
                    state_nxt_s = CLASSIFY;
                end
            end
            DIV0: begin
                if (div_done_s) begin
                    state_nxt_s = DIV1;
                end else begin
                    state_nxt_s = DIV0;
                end
            end
            DIV1: begin
                if (div_done_s) begin
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = DIV1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = ACCUM;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACCUM);
            out_valid_r <= (state_nxt_s == OUT);
        end
    end

    // Datapath: pixel buffer, accumulators, class sums and the output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= 4'd0;
            ysum_r      <= 14'd0;
            sum0_r      <= 36'd0;
            sum1_r      <= 36'd0;
            cnt0_r      <= 5'd0;
            cnt1_r      <= 5'd0;
            bmp_r       <= 16'd0;
            avg0_r      <= 24'd0;
            out_block_r <= 64'd0;
            for (int i = 0; i < 16; i++) begin
                pix_buf_r[i] <= 24'd0;
            end
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        pix_buf_r[cnt_r] <= in_pixel;
                        ysum_r           <= ysum_r + {4'd0, luma(in_pixel)};
                        cnt_r            <= cnt_r + 4'd1;
                    end
                end
                CLASSIFY: begin
                    bmp_r[cnt_r] <= cls_bit_s;
                    cnt_r        <= cnt_r + 4'd1;
                    if (cls_bit_s) begin
                        cnt1_r <= cnt1_r + 5'd1;
                        for (int l = 0; l < 3; l++) begin
                            sum1_r[l*12 +: 12] <= sum1_r[l*12 +: 12] + {4'd0, cur_pix_s[l*8 +: 8]};
                        end
                    end else begin
                        cnt0_r <= cnt0_r + 5'd1;
                        for (int l = 0; l < 3; l++) begin
                            sum0_r[l*12 +: 12] <= sum0_r[l*12 +: 12] + {4'd0, cur_pix_s[l*8 +: 8]};
                        end
                    end
                end
                DIV0: begin
                    if (div_done_s) begin
                        avg0_r <= div_quo_s;
                        cnt_r  <= 4'd0;
                    end else begin
                        cnt_r  <= cnt_r + 4'd1;
                    end
                end
                DIV1: begin
                    if (div_done_s) begin
                        out_block_r[BMP_LSB +: 16] <= bmp_r;
                        out_block_r[C0_LSB +: 24]  <= c0_s;
                        out_block_r[C1_LSB +: 24]  <= c1_s;
                        cnt_r                      <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        cnt_r  <= 4'd0;
                        ysum_r <= 14'd0;
                        sum0_r <= 36'd0;
                        sum1_r <= 36'd0;
                        cnt0_r <= 5'd0;
                        cnt1_r <= 5'd0;
                    end
                end
                default: cnt_r <= 4'd0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;

endmodule

// File: tb/tb_ccc_encoder_4x4.sv
// Randomised self-checking bench for ccc_encoder_4x4 against an arithmetic reference encode.
module tb_ccc_encoder_4x4;

    typedef logic [23:0] blk_t [16];

    localparam int THRESH = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] in_pixel = 24'd0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_block;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ccc_encoder_4x4 #(.THRESH_BIAS(15'(THRESH))) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int round_bias(input int n);
`ifdef CCC_ENC_ROUND_EN
        return n / 2;
`else
        return 0;
`endif
    endfunction

    // Reference encode straight from the block-level rules.
    function automatic logic [63:0] ref_encode(input blk_t p);
        int y [16];
        int ysum = 0;
        int s0 [3];
        int s1 [3];
        int n0 = 0;
        int n1 = 0;
        int a0 [3];
        int a1 [3];
        logic [15:0] bmp = 16'd0;
        for (int k = 0; k < 3; k++) begin
            s0[k] = 0;
            s1[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            y[i] = int'(p[i][23:16]) + 2 * int'(p[i][15:8]) + int'(p[i][7:0]);
            ysum += y[i];
        end
        for (int i = 0; i < 16; i++) begin
            if (16 * y[i] + THRESH > ysum) begin
                bmp[i] = 1'b1;
                n1++;
                for (int k = 0; k < 3; k++) s1[k] += int'(p[i][23 - 8*k -: 8]);
            end else begin
                n0++;
                for (int k = 0; k < 3; k++) s0[k] += int'(p[i][23 - 8*k -: 8]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            a0[k] = (n0 > 0) ? (s0[k] + round_bias(n0)) / n0 : 0;
            a1[k] = (n1 > 0) ? (s1[k] + round_bias(n1)) / n1 : 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (n0 == 0) a0[k] = a1[k];
            if (n1 == 0) a1[k] = a0[k];
        end
        return {8'(a1[0]), 8'(a1[1]), 8'(a1[2]), 8'(a0[0]), 8'(a0[1]), 8'(a0[2]), bmp};
    endfunction

    // Streams one block, optionally with random idle gaps; returns the cycle stamp after pixel 15.
    task automatic send_block(input blk_t p, input bit gaps, output int acc_cyc);
        int bound;
        int g;
        acc_cyc = cyc;
        for (int i = 0; i < 16; i++) begin
            g = 0;
            while (gaps && (g < 8) && ($urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                in_pixel = 24'($urandom);
                @(negedge clk);
                g++;
            end
            in_valid = 1'b1;
            in_pixel = p[i];
            bound = 0;
            while ((in_ready !== 1'b1) && (bound < 300)) begin
                @(negedge clk);
                bound++;
            end
            if (in_ready !== 1'b1) begin
                check_eq("send_ready", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_pixel = 24'($urandom);
        acc_cyc = cyc;
    endtask

    // Waits for the block word, checks it, holds back-pressure, then completes one handshake.
    task automatic recv_block(input string tag, input logic [63:0] exp, input int acc_cyc,
                              input bit chk_lat, input int hold);
        int bound = 0;
        int bad = 0;
        logic [63:0] first;
        while ((out_valid !== 1'b1) && (bound < 300)) begin
            @(negedge clk);
            bound++;
        end
        check_eq({tag, ":valid"}, 64'(out_valid), 64'd1);
        if (out_valid !== 1'b1) return;
        if (chk_lat) check_eq({tag, ":latency"}, 64'(cyc - acc_cyc), 64'd40);
        check_eq({tag, ":block"}, out_block, exp);
        first = out_block;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if ((out_block !== first) || (out_valid !== 1'b1) || (in_ready !== 1'b0)) bad++;
        end
        if (hold > 0) check_eq({tag, ":hold"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ":ready_after"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    function automatic blk_t checker_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        return b;
    endfunction

    initial begin
        blk_t b;
        int acc;
        logic [7:0] exp_r;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {in_ready, out_valid, out_block}, 66'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_release_ready", 64'(in_ready), 64'd1);

        // Uniform block, with exact latency
        for (int i = 0; i < 16; i++) b[i] = 24'h406080;
        send_block(b, 1'b0, acc);
        recv_block("uniform", {24'h406080, 24'h406080, 16'h0000}, acc, 1'b1, 0);
        check_eq("uniform_model", ref_encode(b), {24'h406080, 24'h406080, 16'h0000});

        // Checkerboard
        b = checker_blk();
        send_block(b, 1'b0, acc);
        recv_block("checker", {24'hFFFFFF, 24'h000000, 16'hAAAA}, acc, 1'b1, 0);

        // Rounding: class1 R = 1,1,2 -> 1 in both builds
        for (int i = 0; i < 16; i++) b[i] = 24'h000000;
        b[3] = 24'h010000; b[7] = 24'h010000; b[12] = 24'h020000;
        send_block(b, 1'b0, acc);
        recv_block("round3", ref_encode(b), acc, 1'b0, 0);
        check_eq("round3_r", 64'(ref_encode(b) >> 56), 64'd1);

        // Rounding: class1 R = 1,2 -> 2 when rounding, 1 when truncating
`ifdef CCC_ENC_ROUND_EN
        exp_r = 8'd2;
`else
        exp_r = 8'd1;
`endif
        for (int i = 0; i < 16; i++) b[i] = 24'h000000;
        b[0] = 24'h010000; b[15] = 24'h020000;
        send_block(b, 1'b0, acc);
        recv_block("round2", {exp_r, 16'h0000, 24'h000000, 16'h8001}, acc, 1'b0, 0);

        // Back-pressure for 20 cycles
        for (int i = 0; i < 16; i++) b[i] = 24'($urandom);
        send_block(b, 1'b0, acc);
        recv_block("backpressure", ref_encode(b), acc, 1'b1, 20);

        // Reset after 7 accepted pixels, then a clean checkerboard
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_pixel = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_outputs", {in_ready, out_valid, out_block}, 66'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", 64'(in_ready), 64'd1);
        b = checker_blk();
        send_block(b, 1'b0, acc);
        recv_block("after_rst", {24'hFFFFFF, 24'h000000, 16'hAAAA}, acc, 1'b1, 0);

        // Random blocks with input gaps
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 16; i++) b[i] = 24'($urandom);
            if (n % 10 == 3) begin
                for (int i = 1; i < 16; i++) b[i] = b[0];
            end
            send_block(b, 1'b1, acc);
            recv_block($sformatf("rand%0d", n), ref_encode(b), acc, 1'b1, int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccc_encoder_4x4.md
# ccc_encoder_4x4

Streaming CCC (color cell compression) encoder for one 4x4 pixel block. Accepts 16 RGB888 pixels over a valid/ready stream, forms a 16-bit luminance bitmap and two representative colors, and emits one 64-bit CCC block word over a valid/ready stream. It is the compression-side counterpart of the CCC decode path. A frame-level wrapper tiles or time-multiplexes it, and its output word layout matches the decoder's block format bit for bit.

## Interface
- THRESH_BIAS, default 0: signed 15-bit value added to 16*Y before the threshold compare.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  encoder can accept a pixel beat.
- in_pixel  in  24  {R[23:16], G[15:8], B[7:0]}; pixel order within the block is row-major, pixel 0 is top-left.
- out_valid  out  1  block word valid.
- out_ready  in  1  downstream accepts the block word.
- out_block  out  64  [15:0] bitmap (bit i corresponds to pixel i), [39:16] color0 (bit=0), [63:40] color1 (bit=1); each color is {R,G,B}.

## Operation
- States: ACCUM, CLASSIFY, DIV0, DIV1, OUT.
- ACCUM:
  - in_ready=1.
  - Each in_valid&&in_ready beat stores the pixel into buf[cnt] and adds Y=R+2G+B (10 bits) to ysum (14 bits); cnt then increments.
  - The beat with cnt=15 moves the state to CLASSIFY with cnt=0.
- CLASSIFY: takes 16 cycles, one pixel per cycle.
  - bit_i = (16*Y_i + THRESH_BIAS > ysum), compared as a signed 16-bit value with a strict greater-than.
  - Pixels are accumulated into per-class R/G/B sums (12 bits each) and per-class counts (5 bits).
- DIV0 / DIV1: 12 cycles each. Three parallel 12-bit by 5-bit restoring dividers compute the class0 averages, then the class1 averages.
- Empty class: if a count is 0, the divider result is ignored and that color is copied from the other class. Since the compare is strict, a uniform block yields bitmap 0x0000 and color1 == color0.
- OUT:
  - out_valid=1 and out_block is held stable until out_ready.
  - The handshake returns the state to ACCUM. ysum, sums and counts are cleared in that same edge.
- No overlap between blocks: in_ready=0 in every state except ACCUM.
- Reset (async, any state): state=ACCUM, cnt=0, all accumulators 0, out_valid=0, out_block=0. in_ready reads 1 once reset deasserts. A partial block in progress is discarded.

## Timing
- Values while reset is asserted: in_ready=0, out_valid=0, out_block=64'h0.
- in_ready=1 from the first edge after reset release, and thereafter throughout ACCUM.
- Let edge E be the one accepting pixel 15:
  - Edges E+1..E+16 run CLASSIFY.
  - E+17..E+28 run DIV0.
  - E+29..E+40 run DIV1.
  - out_valid goes high after edge E+40.
- in_ready returns high after the edge on which out_valid&&out_ready.
- Minimum block period: 16 + 40 + 1 = 57 cycles.
- Back-pressure: out_valid stays high and out_block stays unchanged for any number of cycles with out_ready=0.
- A gap in in_valid stalls ACCUM with no effect on the result.

## Configuration
- CCC_ENC_ROUND_EN defined: each dividend is pre-biased by floor(count/2), so averages round to nearest, ties rounding up.
- Undefined: averages are truncated (floor). The dividend is still 12 bits because the maximum biased sum, 4080+8, is below 4096.

## Structure
- ccc_pkg holds:
  - BITS_PER_PIXEL=24 and BITS_PER_BLOCK=64.
  - Field offsets BMP_LSB=0, C0_LSB=16, C1_LSB=40.
  - The state enum ccc_enc_state_t.
  - The function luma(pixel) returning 10 bits.
- Sub-module ccc_div3: three-lane sequential 12-by-5-bit restoring divider with a start/done handshake and a fixed latency of 12 cycles. It is instanced once and reused for DIV0 and DIV1.

## Test plan
- Uniform block: 16 pixels of 0x406080 -> out_block = {0x406080, 0x406080, 16'h0000}; out_valid rises exactly 40 edges after pixel 15 is accepted.
- Checkerboard: even-index pixels 0x000000, odd-index pixels 0xFFFFFF -> bitmap 0xAAAA, color0 0x000000, color1 0xFFFFFF.
- Rounding case: class1 holds 3 pixels with R=1,1,2 (R sum 4, count 3) -> color1.R = 1 in both builds. Class1 with R=1,2 (sum 3, count 2) -> color1.R = 2 with CCC_ENC_ROUND_EN, 1 without.
- Back-pressure: hold out_ready=0 for 20 cycles -> out_block stable, in_ready=0 throughout, a single handshake on release, in_ready=1 on the next cycle.
- Reset after 7 accepted pixels, then a full new checkerboard block -> output equals the checkerboard result, with no contamination from the discarded pixels.
- Random in_valid gaps (50% duty) over 100 random blocks -> every out_block matches the reference-model encode.
